// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one pipelined 19x18 multiplier among N channels.
// It tags each issued operation so the returning product can be routed back to its channel.
`timescale 1ns/1ps
module mul_sched #(
  parameter int N   = 4,
  parameter int LAT = 4,
  parameter int IW  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [19*N-1:0]   a_in,
  input  logic [18*N-1:0]   b_in,
  output logic [N-1:0]      gnt,
  output logic [18:0]       mul_a,
  output logic [17:0]       mul_b,
  output logic              mul_rst,
  input  logic [17:0]       mul_p,
  input  logic              mul_v,
  output logic              res_vld,
  output logic [IW-1:0]     res_id,
  output logic [17:0]       res_p,
  output logic              res_ovf,
  output logic [N-1:0]      ovf_flag,
  input  logic [N-1:0]      ovf_clr,
  output logic              busy
);

  localparam int CW = $clog2(LAT + 1);

  logic [IW-1:0] r_last;
  logic          r_mul_rst;
  logic [CW-1:0] r_rst_cnt;
  logic [18:0]   r_mul_a;
  logic [17:0]   r_mul_b;
  logic [LAT:0]  r_tag_v;
  logic [IW-1:0] r_tag_id [0:LAT];
  logic          r_res_vld;
  logic          r_res_ovf;
  logic [IW-1:0] r_res_id;
  logic [17:0]   r_res_p;
  logic [N-1:0]  r_ovf_flag;

  logic [IW-1:0] w_cand [0:N-1];
  logic          w_found;
  logic [IW-1:0] w_win;
  logic [N-1:0]  w_gnt;
  logic [N-1:0]  w_ovf_set;
  logic [18:0]   w_a;
  logic [17:0]   w_b;

  // w_cand[k] is the channel examined k+1 places after the last winner, wrapped mod N.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] w_sum;
    assign w_sum       = {1'b0, r_last} + (IW+1)'(gi + 1);
    assign w_cand[gi]  = (w_sum >= (IW+1)'(N)) ? (w_sum[IW-1:0] - IW'(N)) : w_sum[IW-1:0];
    assign w_ovf_set[gi] = r_res_vld & r_res_ovf & (r_res_id == IW'(gi));
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[w_cand[k]]) begin
        w_found = 1'b1;
        w_win   = w_cand[k];
      end
    end
    if (r_mul_rst) w_found = 1'b0;
    w_gnt = '0;
    if (w_found) w_gnt[w_win] = 1'b1;
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < N; k++) begin
      if (w_gnt[k]) begin
        w_a = a_in[19*k +: 19];
        w_b = b_in[18*k +: 18];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= IW'(N - 1);
      r_mul_rst  <= 1'b1;
      r_rst_cnt  <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_tag_v    <= '0;
      for (int k = 0; k <= LAT; k++) r_tag_id[k] <= '0;
      r_res_vld  <= 1'b0;
      r_res_ovf  <= 1'b0;
      r_res_id   <= '0;
      r_res_p    <= '0;
      r_ovf_flag <= '0;
    end else begin
      // Keep the multiplier in reset long enough to flush its whole pipeline.
      if (r_mul_rst) begin
        if (r_rst_cnt == CW'(LAT)) r_mul_rst <= 1'b0;
        else                       r_rst_cnt <= r_rst_cnt + 1'b1;
      end
      if (w_found) r_last <= w_win;
      r_mul_a    <= w_a;
      r_mul_b    <= w_b;
      r_tag_v    <= {r_tag_v[LAT-1:0], w_found};
      r_tag_id[0] <= w_win;
      for (int k = 1; k <= LAT; k++) r_tag_id[k] <= r_tag_id[k-1];
      r_res_vld  <= r_tag_v[LAT];
      if (r_tag_v[LAT]) begin
        r_res_p   <= mul_p;
        r_res_ovf <= mul_v;
        r_res_id  <= r_tag_id[LAT];
      end
      r_ovf_flag <= (r_ovf_flag & ~ovf_clr) | w_ovf_set;
    end
  end

  assign gnt      = w_gnt;
  assign mul_a    = r_mul_a;
  assign mul_b    = r_mul_b;
  assign mul_rst  = r_mul_rst;
  assign res_vld  = r_res_vld;
  assign res_id   = r_res_id;
  assign res_p    = r_res_p;
  assign res_ovf  = r_res_ovf;
  assign ovf_flag = r_ovf_flag;
  assign busy     = (|r_tag_v) | r_res_vld;

endmodule

// File: doc/mul_sched.md
# mul_sched

Round-robin scheduler that shares one pipelined 19x18 rounding multiplier (`mul18x19x18p`, 4-clock latency, active-high synchronous reset) among N requesting channels. Channels are typically LO mixers or gain stages. The block does four things:
- accepts one operand pair per clock from the winning channel and drives the multiplier inputs;
- tracks channel tags through a delay line matched to the multiplier latency;
- returns each tagged, registered result with its overflow flag;
- sequences the multiplier's reset after system reset.

## Interface
Parameters:
- `N`, default 4: number of requesting channels, 2..8.
- `LAT`, default 4: multiplier latency in clocks, from A/B input to P output.
- `IW`, default clog2(N): channel-id width.

Ports:
- `clk`  in  1  master clock.
- `rst_n`  in  1  asynchronous, active-low master reset.
- `req`  in  N  per-channel request. Operands must be valid while high.
- `a_in`  in  19*N  channel A operands, packed; channel i occupies [19i+18:19i].
- `b_in`  in  18*N  channel B operands, packed; channel i occupies [18i+17:18i].
- `gnt`  out  N  one-hot grant, combinational. Operands are taken this cycle.
- `mul_a`  out  19  multiplier A input, registered.
- `mul_b`  out  18  multiplier B input, registered.
- `mul_rst`  out  1  multiplier synchronous reset, active-high.
- `mul_p`  in  18  multiplier product.
- `mul_v`  in  1  multiplier overflow.
- `res_vld`  out  1  result valid, one-cycle pulse per result.
- `res_id`  out  IW  channel id of the result.
- `res_p`  out  18  registered product.
- `res_ovf`  out  1  registered overflow for this result.
- `ovf_flag`  out  N  sticky per-channel overflow flags.
- `ovf_clr`  in  N  per-channel clear for the sticky flags.
- `busy`  out  1  high while any issued operation is still in flight.

## Operation
Arbitration:
- Round-robin pointer `last` holds the index of the most recently granted channel; reset value N-1.
- The search starts at `last`+1 and wraps modulo N. The first channel with `req` high wins.
- `gnt` is zero whenever `mul_rst` is high or no `req` is set.
- On a grant, `last` is set to the winner. With no grant, `last` holds.
- At most one grant per clock.

Requester handshake:
- A requester holds `req` and its operands stable until it sees `gnt`.
- It may keep `req` high on the following cycle with new operands; that is a back-to-back request.
- A requester may drop `req` without receiving a grant; no state is kept for it.

Issue:
- On a grant, the winner's operands are registered into `mul_a`/`mul_b`.
- With no grant, `mul_a`/`mul_b` load zero (bubble).
- Tag pipeline is LAT+1 stages of {valid, id}. Stage 0 loads {grant, winner index} together with the operand registers.

Result capture:
- When the last tag stage is valid, `res_p`, `res_ovf` and `res_id` are registered from `mul_p`, `mul_v` and the tag id, and `res_vld` pulses high.
- Otherwise `res_vld` is 0 and `res_p`/`res_id`/`res_ovf` hold their previous values.
- No backpressure: the result sink must accept every result.

Sticky overflow:
- `ovf_flag[i]` sets when `res_vld` and `res_ovf` are both high with `res_id` = i.
- `ovf_flag[i]` clears on `ovf_clr[i]`.
- If set and clear happen in the same cycle, set wins.

`busy` is the OR of all tag-valid bits and `res_vld`.

Reset sequencing:
- `rst_n` low asynchronously clears all registers and asserts `mul_rst`.
- After `rst_n` rises, `mul_rst` stays high for LAT+1 clocks, then drops. Grants are possible only from then on.

## Timing
Reset values:
- `mul_a`, `mul_b`, `res_p`, `res_id`, `res_ovf`, `res_vld`, `ovf_flag`, `busy`, tag pipeline: all 0.
- `mul_rst` = 1.
- `last` = N-1.

Latency and throughput:
- A grant in cycle t puts the operands on `mul_a`/`mul_b` in t+1.
- `mul_p` is valid in t+1+LAT.
- `res_vld` is high in t+2+LAT, which is t+6 for the default LAT.
- Throughput is one operation per clock. Results leave in grant order.

`rst_n` asserted mid-operation:
- All in-flight tags are discarded and no `res_vld` is produced for them.
- The multiplier is held in reset through the release delay.

Fairness: with all N requests continuously high, each channel is granted exactly once every N clocks.

## Test plan
- Reset release: deassert `rst_n`, hold `req`=all ones → `mul_rst` high for 5 clocks after release, `gnt` zero during that time; the first grant is `gnt`=0001 on the first cycle after `mul_rst` drops.
- Single op: ch2 requests with A=0x20000, B=0x0FFFF → `gnt`[2] in cycle t; `res_vld` in t+6 with `res_id`=2 and `res_p` equal to the model product; `busy` high t+1..t+6.
- Full load: all 4 `req` high for 40 clocks → grants rotate 0,1,2,3 repeatedly; 40 results arrive in order, contiguous; each channel gets 10.
- Sparse and dropped requests: ch1 and ch3 alternate, then ch1 drops `req` before being granted → grants alternate ch1/ch3 correctly, and there is no result for the dropped request.
- Overflow: ch0 issues A=-2^18, B=-2^17 → `res_ovf`=1 and `ovf_flag`[0] sets. Pulse `ovf_clr`[0] in the same cycle as a second overflow → the flag stays 1. Clear it alone → the flag becomes 0.
- Reset mid-flight: issue 3 ops, then pulse `rst_n` low 2 cycles later → no `res_vld` afterwards; all outputs return to their reset values immediately, without waiting for a clock edge.
